// File: rtl/prime_sweep.sv
// ---------------------------------------------------------------------------
// prime_sweep
//   Range-scan controller placed in front of the combinational prime
//   detector. After an accepted start it walks a_out through every value in
//   [lo, hi], one value per clock. Each cycle it samples the detector's
//   answer for the registered a_out. When the walk ends it reports the
//   number of primes seen, the largest one, and pulses done.
//
//   Optional build macro: PRIME_SWEEP_SELFCHK_EN
//     When defined, an internal trial-division reference checks every
//     detector answer during SCAN. Any disagreement sets the sticky
//     mismatch flag. Counting still follows the detector, not the
//     reference. When the macro is undefined, mismatch is tied to 0.
//
// Ports
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset
//   start        sweep request, sampled only while idle
//   lo, hi       inclusive range bounds, captured on an accepted start
//   a_out        value presented to the detector input
//   is_prime_in  detector verdict for the current a_out
//   busy         high during SCAN cycles
//   done         one-cycle completion pulse
//   range_err    lo > hi on the last accepted start
//   prime_count  primes counted in the last sweep (WIDTH+1 bits)
//   last_prime   largest prime seen in the last sweep, 0 if none
//   found        at least one prime seen in the last sweep
//   mismatch     sticky detector/reference disagreement
// ---------------------------------------------------------------------------
module prime_sweep #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] a_out,
  input  logic             is_prime_in,
  output logic             busy,
  output logic             done,
  output logic             range_err,
  output logic [WIDTH:0]   prime_count,
  output logic [WIDTH-1:0] last_prime,
  output logic             found,
  output logic             mismatch
);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] hi_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      hi_reg      <= '0;
      a_out       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      range_err   <= 1'b0;
      prime_count <= '0;
      last_prime  <= '0;
      found       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            hi_reg      <= hi;
            prime_count <= '0;
            last_prime  <= '0;
            found       <= 1'b0;
            range_err   <= 1'b0;
            if (lo <= hi) begin
              a_out     <= lo;
              busy      <= 1'b1;
              state_reg <= SCAN;
            end else begin
              // Empty range: nothing is driven. FIN raises done one cycle
              // later, so done comes two cycles after the start edge.
              range_err <= 1'b1;
              state_reg <= FIN;
            end
          end
        end

        SCAN: begin
          if (is_prime_in) begin
            prime_count <= prime_count + 1'b1;
            last_prime  <= a_out;
            found       <= 1'b1;
          end
          // Compare for equality before incrementing, so hi = all-ones
          // finishes without a_out wrapping around.
          if (a_out == hi_reg) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= FIN;
          end else begin
            a_out <= a_out + 1'b1;
          end
        end

        FIN: begin
          // Arriving from SCAN, done is already high. Arriving from the
          // range-error path, done is raised here first.
          if (done) begin
            done      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef PRIME_SWEEP_SELFCHK_EN
  // Reference primality by trial division over 2..floor(sqrt(2^WIDTH)).
  function automatic logic golden_prime(input logic [WIDTH-1:0] v);
    int unsigned vi;
    logic        p;
    vi = 32'(v);
    p  = (vi >= 32'd2);
    for (int unsigned d = 2; d * d <= (32'd1 << WIDTH); d++) begin
      if (vi > d && (vi % d) == 32'd0) p = 1'b0;
    end
    return p;
  endfunction

  logic mismatch_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_reg <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      mismatch_reg <= 1'b0;
    end else if (state_reg == SCAN && golden_prime(a_out) != is_prime_in) begin
      mismatch_reg <= 1'b1;
    end
  end

  assign mismatch = mismatch_reg;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: doc/prime_sweep.md
Name: prime_sweep

Overview:
- Sequential sweep controller that sits directly upstream of the combinational 5-bit prime detector.
- On a start request it drives the detector input through every value in the range [lo, hi], one value per clock.
- It samples the detector's 1-bit prime flag each cycle and reports three results: number of primes found, largest prime found, and completion.
- Turns the stand-alone detector into a usable range-scan engine for the arithmetic-lab top level.

Parameters:
- WIDTH, 5, bit width of swept values; must match the detector input width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  sweep request; sampled only in IDLE
- lo  input  WIDTH  first value of range; captured on accepted start
- hi  input  WIDTH  last value of range, inclusive; captured on accepted start
- a_out  output  WIDTH  value driven to detector input A
- is_prime_in  input  1  detector output Y for the current a_out (combinational return path)
- busy  output  1  high while sweep in progress
- done  output  1  one-cycle pulse when sweep ends
- range_err  output  1  high with done when lo > hi; held until next accepted start
- prime_count  output  WIDTH+1  number of primes seen in last sweep (max 2^WIDTH)
- last_prime  output  WIDTH  largest prime seen (last hit in ascending order); 0 if none
- found  output  1  at least one prime seen in last sweep
- mismatch  output  1  sticky self-check failure (see Optional Feature)

Behaviour:
- Asynchronous reset (rst_n low), all outputs immediately: a_out=0, busy=0, done=0, range_err=0, prime_count=0, last_prime=0, found=0, mismatch=0; state=IDLE.
- FSM states: IDLE, SCAN, FIN.
- IDLE:
  - start=1 at edge t: capture lo/hi, clear prime_count/last_prime/found/range_err/mismatch.
  - If lo <= hi: a_out=lo, busy=1, go SCAN at t+1.
  - If lo > hi: range_err=1, go FIN; no value is driven and prime_count stays 0.
- SCAN, each cycle:
  - is_prime_in belongs to the current registered a_out.
  - If is_prime_in=1: prime_count+=1, last_prime=a_out, found=1.
  - If a_out==hi_captured: go FIN. Otherwise a_out+=1.
  - One value per cycle; a range of N values occupies exactly N SCAN cycles.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
  - Results and a_out hold until the next accepted start.
- start is ignored while busy or in FIN; no queuing.
- a_out never wraps: the end check uses equality with hi before incrementing, so hi = 2^WIDTH-1 ends cleanly.
- lo == hi: single SCAN cycle.
- prime_count is WIDTH+1 bits, so a full-range sweep cannot overflow.
- Reset asserted mid-sweep: abort immediately to reset values; no done pulse.
- Latency: accepted start at edge t, first sample in cycle t+1, done high in cycle t+N+1 for N=hi-lo+1.

Optional Feature:
- Macro: PRIME_SWEEP_SELFCHK_EN.
- Defined:
  - An internal golden primality function (trial division by 2..floor(sqrt(2^WIDTH)); 0 and 1 non-prime) is evaluated on a_out in every SCAN cycle.
  - If it disagrees with is_prime_in, mismatch is set and stays set until the next accepted start or reset.
  - Counting still uses is_prime_in, not the golden value.
- Undefined: no checker logic; mismatch tied to 0.

Test Plan:
- Reset, then start with lo=0, hi=31 against a correct detector model: busy for 32 cycles; done in cycle 33 after start; prime_count=11, last_prime=31, found=1, range_err=0.
- lo=2, hi=2: exactly 1 SCAN cycle, a_out=2; done at t+2; prime_count=1, last_prime=2.
- lo=24, hi=28: prime_count=0, found=0, last_prime=0, a_out=28 after done.
- lo=10, hi=5: done at t+2 with range_err=1, prime_count=0, busy never asserted; start pulses during a 32-value sweep are ignored and counts are unaffected.
- rst_n low at SCAN cycle 7 of a 0..31 sweep: all outputs 0 immediately, no done; a new start afterwards completes normally with prime_count=11.
- With PRIME_SWEEP_SELFCHK_EN, detector model falsely flags 25 (0..31 sweep): mismatch=1 from the cycle after a_out=25, prime_count=12; without the macro mismatch stays 0.
